avr_irq_ctrl: RTL and testbench

Programmable interrupt controller between the peripheral interrupt lines (UART, keypad, timers, …) and the AVR core's `iflag`/`ivect`/ack interrupt interface. Synchronises raw request lines, latches edge- or level-type requests into a pending register, applies a software mask and selects one vector by priority. It holds that vector stable until the core acknowledges it. It is programmed by the core through four I/O-space registers, decoded from `io_a` by the top level in the same way as the UART window.

---
 rtl/avr_irq_pkg.sv | 18 +
 rtl/avr_irq_ctrl_if.sv | 30 +++
 rtl/irq_sync.sv | 30 +++
 rtl/avr_irq_ctrl.sv | 150 +++++++++++++++
 tb/tb_avr_irq_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/avr_irq_pkg.sv
// Shared constants for the AVR interrupt controller: register indices,
// STAT layout and the request/acknowledge state encoding.
package avr_irq_pkg;

  localparam logic [1:0] IRQ_REG_PEND = 2'd0;
  localparam logic [1:0] IRQ_REG_MASK = 2'd1;
  localparam logic [1:0] IRQ_REG_EDGE = 2'd2;
  localparam logic [1:0] IRQ_REG_STAT = 2'd3;

  localparam int IRQ_STAT_FLAG = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } irq_state_e;

endpackage

// File: rtl/avr_irq_ctrl_if.sv
// Core-side bus of the interrupt controller: the I/O register window plus the
// iflag/ivect/ack interrupt handshake.
interface avr_irq_ctrl_if #(
  parameter int IVW = 2
);
  // Register access: io_re/io_we are single-cycle strobes; io_di is valid the
  // cycle after io_re and holds otherwise.
  // Interrupt handshake: iflag acts as valid with ivect as its payload; ivect
  // stays frozen while iflag is high, and the transfer completes only on a
  // cycle where ack is high with ack_vect equal to ivect.
  logic           io_re;
  logic           io_we;
  logic [1:0]     io_a;
  logic [7:0]     io_do;
  logic [7:0]     io_di;
  logic           iflag;
  logic [IVW-1:0] ivect;
  logic           ack;
  logic [IVW-1:0] ack_vect;

  modport master (
    output io_re, io_we, io_a, io_do, ack, ack_vect,
    input  io_di, iflag, ivect
  );

  modport slave (
    input  io_re, io_we, io_a, io_do, ack, ack_vect,
    output io_di, iflag, ivect
  );
endinterface

// File: rtl/irq_sync.sv
// W-bit multi-stage synchroniser; the last stage is delayed once more to
// produce a single-cycle rising-edge strobe per bit.
module irq_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] level,
  output logic [W-1:0] rise
);

  logic [STAGES-1:0][W-1:0] stage_q;
  logic [W-1:0]             dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      dly_q   <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d};
      dly_q   <= stage_q[STAGES-1];
    end
  end

  assign level = stage_q[STAGES-1];
  assign rise  = stage_q[STAGES-1] & ~dly_q;

endmodule

// File: rtl/avr_irq_ctrl.sv
// Programmable interrupt controller for the AVR core. Defining
// AVR_IRQ_ROTATE_EN selects round-robin priority instead of fixed priority.
module avr_irq_ctrl
  import avr_irq_pkg::*;
#(
  parameter int N_IRQ       = 4,
  parameter int IVW         = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq_in,
  avr_irq_ctrl_if.slave    bus,
  output irq_state_e       dbg_state
);

  irq_state_e       state, state_nx;
  logic [IVW-1:0]   ivect_r, ivect_nx;
  logic [N_IRQ-1:0] pend_r, pend_nx, mask_r, edge_r, cand;
  logic [N_IRQ-1:0] sync_lvl, sync_rise;
  logic [7:0]       io_di_r, rd_data;
  logic             ack_hit, wr_pend;
  logic [IVW-1:0]   ptr;
  logic             unused_do;

  irq_sync #(.W(N_IRQ), .STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (irq_in),
    .level (sync_lvl),
    .rise  (sync_rise)
  );

`ifdef AVR_IRQ_ROTATE_EN
  // Search starts at ptr and wraps, so the source after the last served one wins.
  function automatic logic [IVW-1:0] pick_vect(input logic [N_IRQ-1:0] c,
                                               input logic [IVW-1:0] start);
    logic [IVW-1:0] sel;
    logic           found;
    int             idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < N_IRQ; k++) begin
      idx = (int'(start) + k) % N_IRQ;
      if (!found && c[idx]) begin
        sel   = IVW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr <= '0;
    else if (ack_hit) ptr <= IVW'((int'(bus.ack_vect) + 1) % N_IRQ);
  end
`else
  function automatic logic [IVW-1:0] pick_vect(input logic [N_IRQ-1:0] c,
                                               input logic [IVW-1:0] start);
    logic [IVW-1:0] sel;
    sel = start;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (c[k]) sel = IVW'(k);
    end
    return sel;
  endfunction

  assign ptr = '0;
`endif

  assign cand      = pend_r & mask_r;
  assign wr_pend   = bus.io_we && (bus.io_a == IRQ_REG_PEND);
  assign unused_do = ^bus.io_do;

  always_comb begin
    state_nx = state;
    ivect_nx = ivect_r;
    ack_hit  = 1'b0;
    case (state)
      IDLE: begin
        if (|cand) begin
          ivect_nx = pick_vect(cand, ptr);
          state_nx = REQ;
        end
      end
      REQ: begin
        if (bus.ack && (bus.ack_vect == ivect_r)) begin
          ack_hit  = 1'b1;
          state_nx = GAP;
        end else if (!cand[ivect_r]) begin
          state_nx = IDLE;
        end
      end
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Edge bits: a new rising edge beats any same-cycle clear.
  always_comb begin
    pend_nx = pend_r;
    for (int i = 0; i < N_IRQ; i++) begin
      if (edge_r[i]) begin
        pend_nx[i] = sync_rise[i] |
                     (pend_r[i] & ~((wr_pend && bus.io_do[i]) ||
                                    (ack_hit && (ivect_r == IVW'(i)))));
      end else begin
        pend_nx[i] = sync_lvl[i];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (bus.io_a)
      IRQ_REG_PEND: rd_data[N_IRQ-1:0] = pend_r;
      IRQ_REG_MASK: rd_data[N_IRQ-1:0] = mask_r;
      IRQ_REG_EDGE: rd_data[N_IRQ-1:0] = edge_r;
      IRQ_REG_STAT: begin
        rd_data[IRQ_STAT_FLAG] = (state == REQ);
        rd_data[IVW-1:0]       = ivect_r;
      end
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ivect_r <= '0;
      pend_r  <= '0;
      mask_r  <= '0;
      edge_r  <= '0;
      io_di_r <= '0;
    end else begin
      state   <= state_nx;
      ivect_r <= ivect_nx;
      pend_r  <= pend_nx;
      if (bus.io_we && (bus.io_a == IRQ_REG_MASK)) mask_r <= bus.io_do[N_IRQ-1:0];
      if (bus.io_we && (bus.io_a == IRQ_REG_EDGE)) edge_r <= bus.io_do[N_IRQ-1:0];
      if (bus.io_re) io_di_r <= rd_data;
    end
  end

  assign bus.iflag = (state == REQ);
  assign bus.ivect = ivect_r;
  assign bus.io_di = io_di_r;
  assign dbg_state = state;

endmodule

// File: tb/tb_avr_irq_ctrl.sv
// Self-checking bench for avr_irq_ctrl; expected read data and served vectors
// go through a scoreboard queue. Follows AVR_IRQ_ROTATE_EN like the design.
module tb_avr_irq_ctrl;
  import avr_irq_pkg::*;

  localparam int N_IRQ = 4;
  localparam int IVW   = 2;
  localparam int SYNC  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_IRQ-1:0] irq_in;
  irq_state_e       dbg_state;

  avr_irq_ctrl_if #(.IVW(IVW)) bus ();

  avr_irq_ctrl #(.N_IRQ(N_IRQ), .IVW(IVW), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .irq_in    (irq_in),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] exp_q[$];
  int         model_ptr = 0;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [7:0] got);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got 0x%02h expected <scoreboard empty>", tag, got);
    end else begin
      check_val(tag, got, exp_q.pop_front());
    end
  endtask

  // Priority model: first set bit searching from 'start' with wrap-around.
  function automatic int first_from(input logic [N_IRQ-1:0] set, input int start);
    for (int k = 0; k < N_IRQ; k++) begin
      if (set[(start + k) % N_IRQ]) return (start + k) % N_IRQ;
    end
    return 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
    bus.io_we = 1'b1;
    bus.io_a  = a;
    bus.io_do = d;
    tick();
    bus.io_we = 1'b0;
  endtask

  task automatic reg_read(input string tag, input logic [1:0] a, input logic [7:0] exp);
    exp_q.push_back(exp);
    bus.io_re = 1'b1;
    bus.io_a  = a;
    tick();
    bus.io_re = 1'b0;
    sb_check(tag, bus.io_di);
  endtask

  task automatic do_ack(input logic [IVW-1:0] v, input bit matched);
    bus.ack      = 1'b1;
    bus.ack_vect = v;
    tick();
    bus.ack      = 1'b0;
`ifdef AVR_IRQ_ROTATE_EN
    if (matched) model_ptr = (int'(v) + 1) % N_IRQ;
`else
    if (matched) model_ptr = 0;
`endif
  endtask

  // Counts ticks (continuing from 'start') until iflag equals lvl; -1 on timeout.
  task automatic wait_flag(input logic lvl, input int start, output int n);
    n = start;
    if (bus.iflag === lvl) return;
    for (int i = 0; i < 20; i++) begin
      tick();
      n++;
      if (bus.iflag === lvl) return;
    end
    n = -1;
  endtask

  // ---------------- stimulus ----------------
  int n;
  int v1, v2;

  initial begin
    bus.io_re = 1'b0; bus.io_we = 1'b0; bus.io_a = '0; bus.io_do = '0;
    bus.ack = 1'b0; bus.ack_vect = '0;
    irq_in = 4'b0001;
    rst_n  = 1'b0;
    repeat (3) tick();
    check_val("rst_iflag", 8'(bus.iflag), 8'h00);
    check_val("rst_ivect", 8'(bus.ivect), 8'h00);
    check_val("rst_io_di", bus.io_di, 8'h00);
    rst_n = 1'b1;
    repeat (5) tick();
    reg_read("rst_pend", IRQ_REG_PEND, 8'h01);
    reg_read("rst_mask", IRQ_REG_MASK, 8'h00);
    reg_read("rst_edge", IRQ_REG_EDGE, 8'h00);
    reg_read("rst_stat", IRQ_REG_STAT, 8'h00);
    check_val("masked_no_iflag", 8'(bus.iflag), 8'h00);

    // single edge pulse on source 2
    irq_in = '0;
    repeat (5) tick();
    reg_write(IRQ_REG_EDGE, 8'h0F);
    reg_write(IRQ_REG_MASK, 8'hFF);
    reg_read("mask_upper_ignored", IRQ_REG_MASK, 8'h0F);
    reg_read("edge_rw", IRQ_REG_EDGE, 8'h0F);
    irq_in = 4'b0100;
    exp_q.push_back(8'd2);
    tick();
    irq_in = '0;
    wait_flag(1'b1, 1, n);
    check_val("pulse_latency", 8'(n), 8'(SYNC + 2));
    sb_check("pulse_ivect", 8'(bus.ivect));
    reg_read("stat_in_req", IRQ_REG_STAT, 8'h82);
    do_ack(2'd2, 1'b1);
    check_val("ack_drops_iflag", 8'(bus.iflag), 8'h00);
    reg_read("pend_after_ack", IRQ_REG_PEND, 8'h00);

    // two simultaneous edge requests
    v1 = first_from(4'b1010, model_ptr);
    v2 = (v1 == 1) ? 3 : 1;
    exp_q.push_back(8'(v1));
    exp_q.push_back(8'(v2));
    irq_in = 4'b1010;
    tick();
    irq_in = '0;
    wait_flag(1'b1, 1, n);
    check_val("dual_latency", 8'(n), 8'(SYNC + 2));
    sb_check("dual_first", 8'(bus.ivect));
    do_ack(IVW'(v1), 1'b1);
    wait_flag(1'b1, 1, n);
    check_val("dual_gap_latency", 8'(n), 8'd3);
    sb_check("dual_second", 8'(bus.ivect));
    do_ack(IVW'(v2), 1'b1);
    check_val("dual_done_iflag", 8'(bus.iflag), 8'h00);

    // level source 0, mismatched ack, then line drop
    reg_write(IRQ_REG_EDGE, 8'h0E);
    repeat (2) tick();
    exp_q.push_back(8'd0);
    irq_in = 4'b0001;
    wait_flag(1'b1, 0, n);
    check_val("level_latency", 8'(n), 8'(SYNC + 2));
    sb_check("level_ivect", 8'(bus.ivect));
    do_ack(2'd1, 1'b0);
    check_val("bad_ack_iflag", 8'(bus.iflag), 8'h01);
    check_val("bad_ack_ivect", 8'(bus.ivect), 8'h00);
    irq_in = '0;
    wait_flag(1'b0, 0, n);
    check_val("level_drop_latency", 8'(n), 8'(SYNC + 2));
    reg_read("level_pend_clear", IRQ_REG_PEND, 8'h00);

    // edge set colliding with PEND write-1 on bit 0 (bit 0 masked)
    reg_write(IRQ_REG_MASK, 8'h0E);
    reg_write(IRQ_REG_EDGE, 8'h0F);
    repeat (2) tick();
    irq_in = 4'b0001;
    tick();
    tick();
    reg_write(IRQ_REG_PEND, 8'h01);
    reg_read("set_wins_clear", IRQ_REG_PEND, 8'h01);
    reg_write(IRQ_REG_PEND, 8'h00);
    reg_read("pend_write0_noop", IRQ_REG_PEND, 8'h01);
    reg_write(IRQ_REG_PEND, 8'h01);
    reg_read("pend_write1_clear", IRQ_REG_PEND, 8'h00);
    check_val("masked_pend_no_iflag", 8'(bus.iflag), 8'h00);
    irq_in = '0;
    repeat (3) tick();

    // reset in the middle of a request
    reg_write(IRQ_REG_MASK, 8'h0F);
    exp_q.push_back(8'd2);
    irq_in = 4'b0100;
    tick();
    irq_in = '0;
    wait_flag(1'b1, 1, n);
    check_val("pre_reset_latency", 8'(n), 8'(SYNC + 2));
    sb_check("pre_reset_ivect", 8'(bus.ivect));
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_iflag", 8'(bus.iflag), 8'h00);
    check_val("async_rst_ivect", 8'(bus.ivect), 8'h00);
    model_ptr = 0;
    tick();
    rst_n = 1'b1;
    tick();
    reg_read("post_rst_mask", IRQ_REG_MASK, 8'h00);
    reg_read("post_rst_pend", IRQ_REG_PEND, 8'h00);
    repeat (5) tick();
    check_val("post_rst_iflag", 8'(bus.iflag), 8'h00);

    // ---------------- report ----------------
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_drain: got %0d leftover entries expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
